// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler
// Sequences a SAR ADC: an offset calibration first, then periodic
// conversions spaced by a programmable number of idle cycles, with
// calibration on request, a wait timeout and a sticky error flag.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   en              enables periodic conversions
//   interval[15:0]  idle cycles between conversions
//   cal_req         one-cycle calibration request (latched as pending)
//   adc_done        SAR done, asynchronous to clk (2-flop synchronised)
//   adc_result[9:0] SAR result, stable while adc_done is high
//   st_conv         one-cycle start pulse to the SAR
//   cal             calibration mode to the SAR
//   sample_data     (corrected) conversion result
//   sample_valid    one-cycle strobe for sample_data
//   offset_code     last calibration result; offset_valid once loaded
//   busy            a start or wait state is active
//   timeout_err     sticky; cleared by rst or an accepted cal_req
//
// Build option: define OFFSET_CORR_EN to subtract offset_code and add
// MIDSCALE to every conversion result (saturated to 0..1023).
//
// Handshake: st_conv is a one-cycle pulse that starts the SAR; the SAR
// answers with a rising edge on adc_done, and adc_result must be stable
// while adc_done is high. Only the rising edge of the synchronised
// adc_done is acted on, and only in CAL_WAIT or CONV_WAIT.
module adc_conv_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MIDSCALE       = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] interval,
  input  logic        cal_req,
  input  logic        adc_done,
  input  logic [9:0]  adc_result,
  output logic        st_conv,
  output logic        cal,
  output logic [9:0]  sample_data,
  output logic        sample_valid,
  output logic [9:0]  offset_code,
  output logic        offset_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CAL_START, CAL_WAIT, GAP, CONV_START, CONV_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          pend_q, pend_d;
  logic          st_conv_q, st_conv_d;
  logic          cal_q, cal_d;
  logic          busy_q, busy_d;
  logic          sample_valid_q, sample_valid_d;
  logic [9:0]    sample_data_q, sample_data_d;
  logic [9:0]    offset_code_q, offset_code_d;
  logic          offset_valid_q, offset_valid_d;
  logic          timeout_err_q, timeout_err_d;
  logic          done_edge;
  logic [9:0]    corr_data;

  // sync3_q is the previous synchronised value, used only for edge detect
  assign done_edge = sync2_q & ~sync3_q;

`ifdef OFFSET_CORR_EN
  localparam logic signed [11:0] MID12 = 12'(MIDSCALE);
  logic signed [11:0] corr_sum;
  assign corr_sum = $signed({2'b00, adc_result}) - $signed({2'b00, offset_code_q}) + MID12;
  always_comb begin
    if (corr_sum < 12'sd0)         corr_data = 10'd0;
    else if (corr_sum > 12'sd1023) corr_data = 10'd1023;
    else                           corr_data = corr_sum[9:0];
  end
`else
  assign corr_data = adc_result;
`endif

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    pend_d         = pend_q | cal_req;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    offset_code_d  = offset_code_q;
    offset_valid_d = offset_valid_q;
    // Accepting a calibration request clears the sticky error
    timeout_err_d  = timeout_err_q & ~cal_req;

    case (state_q)
      IDLE: begin
        if (en) state_d = (pend_d || !offset_valid_q) ? CAL_START : CONV_START;
      end
      CAL_START:  state_d = CAL_WAIT;
      CONV_START: state_d = CONV_WAIT;
      CAL_WAIT: begin
        if (done_edge) begin
          offset_code_d  = adc_result;
          offset_valid_d = 1'b1;
          state_d        = en ? GAP : IDLE;
        end else if (wait_cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = en ? GAP : IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      CONV_WAIT: begin
        if (done_edge) begin
          sample_data_d  = corr_data;
          sample_valid_d = 1'b1;
          state_d        = en ? GAP : IDLE;
        end else if (wait_cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = en ? GAP : IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      GAP: begin
        // A pending calibration waits for the normal gap expiry, then wins
        if (!en)                    state_d = IDLE;
        else if (gap_cnt_q == 16'd0) state_d = pend_d ? CAL_START : CONV_START;
        else                        gap_cnt_d = gap_cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Entry actions
    if (state_d == GAP && state_q != GAP) gap_cnt_d = interval;
    if ((state_d == CAL_WAIT || state_d == CONV_WAIT) && state_q != state_d) wait_cnt_d = '0;
    if (state_d == CAL_START) pend_d = 1'b0;

    // Registered outputs follow the next state
    st_conv_d = (state_d == CAL_START) || (state_d == CONV_START);
    cal_d     = (state_d == CAL_START) || (state_d == CAL_WAIT);
    busy_d    = (state_d == CAL_START) || (state_d == CAL_WAIT) ||
                (state_d == CONV_START) || (state_d == CONV_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      gap_cnt_q      <= '0;
      wait_cnt_q     <= '0;
      pend_q         <= 1'b0;
      st_conv_q      <= 1'b0;
      cal_q          <= 1'b0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      offset_code_q  <= '0;
      offset_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= adc_done;
      sync2_q        <= sync1_q;
      sync3_q        <= sync2_q;
      gap_cnt_q      <= gap_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      pend_q         <= pend_d;
      st_conv_q      <= st_conv_d;
      cal_q          <= cal_d;
      busy_q         <= busy_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      offset_code_q  <= offset_code_d;
      offset_valid_q <= offset_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign st_conv      = st_conv_q;
  assign cal          = cal_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign offset_code  = offset_code_q;
  assign offset_valid = offset_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler. A small SAR model answers every
// st_conv with adc_done five cycles later: 612 (512 + 100 offset) in
// calibration mode, otherwise the raw code from the vector table.
module tb_adc_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] interval = 16'd10;
  logic        cal_req = 1'b0;
  logic        adc_done = 1'b0;
  logic [9:0]  adc_result = 10'd0;
  logic        st_conv, cal, sample_valid, offset_valid, busy, timeout_err;
  logic [9:0]  sample_data, offset_code;

  adc_conv_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .interval(interval), .cal_req(cal_req),
    .adc_done(adc_done), .adc_result(adc_result), .st_conv(st_conv), .cal(cal),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .offset_code(offset_code), .offset_valid(offset_valid), .busy(busy),
    .timeout_err(timeout_err)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit model_en = 1'b1;
  logic [9:0] next_raw = 10'd0;
  int done_cyc = 0;

  typedef struct {
    logic [9:0] raw;
    logic [9:0] exp_plain;
    logic [9:0] exp_corr;
  } vec_t;
  vec_t vec[8];

  // SAR model, sampled on the falling edge
  initial begin
    logic c;
    forever begin
      @(negedge clk);
      if (st_conv === 1'b1 && model_en) begin
        c = cal;
        repeat (5) @(negedge clk);
        adc_result = c ? 10'd612 : next_raw;
        adc_done = 1'b1;
        done_cyc = cyc;
        repeat (3) @(negedge clk);
        adc_done = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_data(input int i);
`ifdef OFFSET_CORR_EN
    return vec[i].exp_corr;
`else
    return vec[i].exp_plain;
`endif
  endfunction

  // which: 0 st_conv, 1 sample_valid, 2 timeout_err, 3 offset_valid, 4 cal low
  task automatic wait_sig(input int which, input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = (st_conv === 1'b1);
        1: ok = (sample_valid === 1'b1);
        2: ok = (timeout_err === 1'b1);
        3: ok = (offset_valid === 1'b1);
        default: ok = (cal === 1'b0);
      endcase
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, limit);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_st_conv"}, 32'(st_conv), 0);
    chk({tag, "_cal"}, 32'(cal), 0);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_offset_valid"}, 32'(offset_valid), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    chk({tag, "_sample_data"}, 32'(sample_data), 0);
    chk({tag, "_offset_code"}, 32'(offset_code), 0);
  endtask

  initial begin
    bit ok;
    int t, sv_n, st_n, busy_n;

    //           raw      plain    corrected (raw - 612 + 512, clamped)
    vec[0] = '{10'd700,  10'd700,  10'd600};
    vec[1] = '{10'd50,   10'd50,   10'd0};
    vec[2] = '{10'd612,  10'd612,  10'd512};
    vec[3] = '{10'd1000, 10'd1000, 10'd900};
    vec[4] = '{10'd0,    10'd0,    10'd0};
    vec[5] = '{10'd300,  10'd300,  10'd200};
    vec[6] = '{10'd1023, 10'd1023, 10'd923};
    vec[7] = '{10'd800,  10'd800,  10'd700};

    // reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // first calibration, then periodic conversions 10 idle cycles apart
    interval = 16'd10;
    next_raw = vec[0].raw;
    en = 1'b1;
    wait_sig(0, 20, "cal_start", ok);
    chk("cal_high_at_start", 32'(cal), 1);
    chk("busy_at_start", 32'(busy), 1);
    wait_sig(3, 100, "offset_valid", ok);
    chk("offset_code", 32'(offset_code), 612);
    chk("cal_low_after_done", 32'(cal), 0);
    wait_sig(0, 50, "first_conv", ok);
    chk("first_conv_cal", 32'(cal), 0);
    for (int i = 0; i < 5; i++) begin
      wait_sig(1, 100, "sample", ok);
      chk($sformatf("sample_data_%0d", i), 32'(sample_data), 32'(exp_data(i)));
      if (i == 0) chk("done_to_valid_latency", cyc - done_cyc, 3);
      t = cyc;
      if (i < 4) begin
        next_raw = vec[i+1].raw;
        wait_sig(0, 50, "next_conv", ok);
        chk($sformatf("spacing_%0d", i), cyc - t, 11);
        chk($sformatf("conv_cal_%0d", i), 32'(cal), 0);
      end else begin
        model_en = 1'b0;
      end
    end

    // SAR never answers: timeout after 64 wait cycles, no sample
    wait_sig(0, 50, "tmo_conv", ok);
    t = cyc;
    sv_n = 0;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) sv_n++;
      ok = (timeout_err === 1'b1);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_err: never set within 200 cycles");
    end
    chk("timeout_latency", cyc - t, 65);
    chk("timeout_no_sample", sv_n, 0);
    chk("timeout_offset_kept", 32'(offset_code), 612);
    model_en = 1'b1;
    next_raw = vec[5].raw;
    t = cyc;
    wait_sig(0, 50, "post_tmo_conv", ok);
    chk("post_tmo_spacing", cyc - t, 11);
    chk("post_tmo_cal", 32'(cal), 0);

    // cal_req during CONV_WAIT: sample delivered, then a calibration start
    repeat (2) @(negedge clk);
    cal_req = 1'b1;
    @(negedge clk);
    cal_req = 1'b0;
    chk("cal_req_clears_err", 32'(timeout_err), 0);
    wait_sig(1, 100, "sample_during_req", ok);
    chk("sample_during_req", 32'(sample_data), 32'(exp_data(5)));
    t = cyc;
    next_raw = vec[6].raw;
    wait_sig(0, 50, "pending_cal_start", ok);
    chk("pending_cal_high", 32'(cal), 1);
    chk("pending_cal_spacing", cyc - t, 11);
    wait_sig(4, 100, "recal_end", ok);
    chk("recal_offset", 32'(offset_code), 612);

    // en dropped during CONV_WAIT: sample delivered, then idle
    wait_sig(0, 50, "conv_before_drop", ok);
    chk("conv_before_drop_cal", 32'(cal), 0);
    repeat (2) @(negedge clk);
    en = 1'b0;
    wait_sig(1, 100, "sample_after_drop", ok);
    chk("sample_after_drop", 32'(sample_data), 32'(exp_data(6)));
    chk("busy_after_drop", 32'(busy), 0);
    st_n = 0;
    busy_n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (st_conv === 1'b1) st_n++;
      if (busy === 1'b1) busy_n++;
    end
    chk("no_start_when_idle", st_n, 0);
    chk("no_busy_when_idle", busy_n, 0);

    // reset during CONV_WAIT: outputs clear at once, late done ignored
    en = 1'b1;
    wait_sig(0, 20, "conv_before_rst", ok);
    chk("conv_before_rst_cal", 32'(cal), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    sv_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sample_valid === 1'b1) sv_n++;
    end
    chk("no_sample_after_rst", sv_n, 0);

    // interval = 0: conversion starts the cycle after the gap is entered
    interval = 16'd0;
    next_raw = vec[7].raw;
    en = 1'b1;
    wait_sig(0, 20, "cal_after_rst", ok);
    chk("cal_after_rst_high", 32'(cal), 1);
    wait_sig(3, 100, "offset_after_rst", ok);
    t = cyc;
    chk("offset_after_rst", 32'(offset_code), 612);
    wait_sig(0, 20, "zero_interval_conv", ok);
    chk("zero_interval_spacing", cyc - t, 1);
    chk("zero_interval_cal", 32'(cal), 0);
    wait_sig(1, 100, "zero_interval_sample", ok);
    chk("zero_interval_data", 32'(sample_data), 32'(exp_data(7)));
    en = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
